// File: rtl/hex_chars_pkg.sv
// Shared definitions for the HEX display character path.
// Character codes are 3 bits wide; the downstream seven_seg_decoder maps
// H=000, E=001, L=010, O=011 and blank=111. Codes 100-110 are legal
// pass-through values and are never altered by the rotator.
package hex_chars_pkg;

    localparam int CHAR_W = 3;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_H     = 3'b000;
    localparam char_t CH_E     = 3'b001;
    localparam char_t CH_L     = 3'b010;
    localparam char_t CH_O     = 3'b011;
    localparam char_t CH_BLANK = 3'b111;

    // "HELLO" on a 5-digit bank, leftmost character in the top digit.
    localparam int HELLO_DIGITS = 5;
    localparam logic [CHAR_W*HELLO_DIGITS-1:0] HELLO_WORD = {CH_H, CH_E, CH_L, CH_L, CH_O};

    // Width of the rotation-offset counter; never narrower than one bit.
    function automatic int pos_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_word_rotator_if.sv
// Control/data bundle between the word source and the rotator.
// master: drives load/load_word/run/dir/step, observes char_out/pos/tick.
// slave : the rotator itself.
interface hex_word_rotator_if #(
    parameter int DIGITS = 5,
    parameter int POS_W  = hex_chars_pkg::pos_width(DIGITS)
);
    import hex_chars_pkg::*;

    logic                     load;
    logic [CHAR_W*DIGITS-1:0] load_word;
    logic                     run;
    logic                     dir;
    logic                     step;
    logic [CHAR_W*DIGITS-1:0] char_out;
    logic [POS_W-1:0]         pos;
    logic                     tick;

    modport master (
        output load, load_word, run, dir, step,
        input  char_out, pos, tick
    );

    modport slave (
        input  load, load_word, run, dir, step,
        output char_out, pos, tick
    );

endinterface

// File: rtl/hex_word_rotator_tick_prescaler.sv
// Rotation-rate prescaler.
// Ports: CLOCK_50 (clock), reset (sync, active-high), en (count enable,
// the run input), clr (restart from 0, the load input), tick (advance
// request for the current cycle).
// tick is decoded from the count register so the top can apply the rotation
// and register its own tick strobe on the very same edge.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    // Terminal-count decode; a coincident clear suppresses the request.
    always_comb begin
        w_at_max = (r_count == CNT_MAX);
        tick     = en & ~clr & w_at_max;
    end

    // Count 0..TICK_DIV-1 while enabled, hold otherwise, restart on clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (en) begin
            if (w_at_max) begin
                r_count <= {CNT_W{1'b0}};
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/hex_word_rotator.sv
// Scrolling character source for the HEX display bank.
// Ports: CLOCK_50 (clock), reset (sync, active-high), bus (slave side of
// hex_word_rotator_if): load/load_word capture a new word, run enables the
// prescaler, dir selects scroll direction (0 = toward higher digit index),
// step requests one rotation; char_out is the registered word (digit i at
// bits [3i+2:3i]), pos the rotation offset since the last load and tick a
// one-cycle strobe marking prescaler-driven rotations.
module hex_word_rotator
    import hex_chars_pkg::*;
#(
    parameter int DIGITS   = 5,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    hex_word_rotator_if.slave   bus
);

    localparam int WORD_W = CHAR_W * DIGITS;
    localparam int POS_W  = pos_width(DIGITS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIGITS - 1);

    logic [WORD_W-1:0] r_word;
    logic [POS_W-1:0]  r_pos;
    logic              r_tick;

    logic              w_auto;
    logic              w_advance;
    logic [WORD_W-1:0] w_rot_left;
    logic [WORD_W-1:0] w_rot_right;
    logic [WORD_W-1:0] w_word_next;
    logic [POS_W-1:0]  w_pos_next;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (bus.run),
        .clr      (bus.load),
        .tick     (w_auto)
    );

    // Both rotations of the current word plus the matching offset update.
    always_comb begin
        w_rot_left  = {WORD_W{1'b0}};
        w_rot_right = {WORD_W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            w_rot_left[CHAR_W*i +: CHAR_W]  = r_word[CHAR_W*((i + DIGITS - 1) % DIGITS) +: CHAR_W];
            w_rot_right[CHAR_W*i +: CHAR_W] = r_word[CHAR_W*((i + 1) % DIGITS) +: CHAR_W];
        end
        if (bus.dir) begin
            w_word_next = w_rot_right;
            w_pos_next  = (r_pos == {POS_W{1'b0}}) ? POS_MAX : (r_pos - POS_W'(1));
        end else begin
            w_word_next = w_rot_left;
            w_pos_next  = (r_pos == POS_MAX) ? {POS_W{1'b0}} : (r_pos + POS_W'(1));
        end
        // A step coinciding with an automatic advance still rotates once.
        w_advance = w_auto | bus.step;
    end

    // Word, offset and tick registers: reset > load > advance.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_word <= {DIGITS{CH_BLANK}};
            r_pos  <= {POS_W{1'b0}};
            r_tick <= 1'b0;
        end else if (bus.load) begin
            r_word <= bus.load_word;
            r_pos  <= {POS_W{1'b0}};
            r_tick <= 1'b0;
        end else if (w_advance) begin
            r_word <= w_word_next;
            r_pos  <= w_pos_next;
            r_tick <= w_auto;
        end else begin
            r_word <= r_word;
            r_pos  <= r_pos;
            r_tick <= 1'b0;
        end
    end

    assign bus.char_out = r_word;
    assign bus.pos      = r_pos;
    assign bus.tick     = r_tick;

endmodule

// File: tb/tb_hex_word_rotator.sv
// Scoreboard bench for hex_word_rotator (DIGITS=5, TICK_DIV=4).
// The driver applies inputs on the falling edge, advances a digit-array
// reference model and queues the outputs expected after the next rising
// edge; the monitor pops and compares just after every rising edge.
module tb_hex_word_rotator;
    import hex_chars_pkg::*;

    localparam int DIGITS   = 5;
    localparam int TICK_DIV = 4;
    localparam int WORD_W   = 15;
    localparam int POS_W    = 3;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [POS_W-1:0]  pos;
        logic              tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_word_rotator_if #(.DIGITS(DIGITS)) bus ();

    hex_word_rotator #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: one code per digit, offset, prescaler count.
    int   m_dig[DIGITS];
    int   m_pos = 0;
    int   m_cnt = 0;
    bit   m_tick = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [WORD_W-1:0] model_word();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < DIGITS; i++) w[3*i +: 3] = 3'(m_dig[i]);
        return w;
    endfunction

    task automatic drive(input bit r, input bit ld, input logic [WORD_W-1:0] w,
                         input bit rn, input bit dr, input bit st);
        int  nd[DIGITS];
        bit  auto_adv;
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.load      = ld;
        bus.load_word = w;
        bus.run       = rn;
        bus.dir       = dr;
        bus.step      = st;
        if (r) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = 7;
            m_pos = 0; m_cnt = 0; m_tick = 1'b0;
        end else if (ld) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = int'(w[3*i +: 3]);
            m_pos = 0; m_cnt = 0; m_tick = 1'b0;
        end else begin
            auto_adv = rn && (m_cnt == TICK_DIV - 1);
            if (rn) m_cnt = (m_cnt + 1) % TICK_DIV;
            if (auto_adv || st) begin
                for (int i = 0; i < DIGITS; i++)
                    nd[i] = dr ? m_dig[(i + 1) % DIGITS] : m_dig[(i + DIGITS - 1) % DIGITS];
                m_dig = nd;
                m_pos = dr ? (m_pos + DIGITS - 1) % DIGITS : (m_pos + 1) % DIGITS;
            end
            m_tick = auto_adv;
        end
        e.word = model_word();
        e.pos  = POS_W'(m_pos);
        e.tick = m_tick;
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per applied edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_char_out", 32'(bus.char_out), 32'(e.word));
                check("sb_pos",      32'(bus.pos),      32'(e.pos));
                check("sb_tick",     32'(bus.tick),     32'(e.tick));
            end
        end
    end

    initial begin
        logic [WORD_W-1:0] rw;
        int guard;
        rst = 1'b1; bus.load = 1'b0; bus.load_word = '0;
        bus.run = 1'b0; bus.dir = 1'b0; bus.step = 1'b0;

        // Reset for two cycles with random other inputs.
        for (int k = 0; k < 2; k++) begin
            rw = WORD_W'($urandom);
            drive(1'b1, 1'($urandom), rw, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        after_edge();
        check("reset_word", 32'(bus.char_out), 32'h7FFF);
        check("reset_pos",  32'(bus.pos),      32'd0);
        check("reset_tick", 32'(bus.tick),     32'd0);

        // Load HELLO.
        drive(1'b0, 1'b1, HELLO_WORD, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("load_word", 32'(bus.char_out), 32'h0293);

        // Five left rotations bring HELLO back with pos 0.
        for (int k = 0; k < 5 * TICK_DIV; k++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        after_edge();
        check("left_wrap_word", 32'(bus.char_out), 32'(HELLO_WORD));
        check("left_wrap_pos",  32'(bus.pos),      32'd0);
        check("left_wrap_tick", 32'(bus.tick),     32'd1);

        // One right rotation from HELLO gives OHELL, pos 4.
        for (int k = 0; k < TICK_DIV; k++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        after_edge();
        rw = {CH_O, CH_H, CH_E, CH_L, CH_L};
        check("right_word", 32'(bus.char_out), 32'(rw));
        check("right_pos",  32'(bus.pos),      32'd4);
        for (int k = 0; k < TICK_DIV; k++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Step with run low, then a few held cycles.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Step coincident with an automatic tick.
        guard = 0;
        while (m_cnt != TICK_DIV - 1 && guard < 10) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Load coincident with a tick, then run on to the next tick.
        guard = 0;
        while (m_cnt != TICK_DIV - 1 && guard < 10) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b0, 1'b1, {CH_L, 3'b100, 3'b101, 3'b110, CH_E}, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < TICK_DIV + 1; k++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Reset mid-count.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, HELLO_WORD, 1'b1, 1'b0, 1'b1);
        after_edge();
        check("midreset_word", 32'(bus.char_out), 32'h7FFF);
        check("midreset_pos",  32'(bus.pos),      32'd0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rw = WORD_W'($urandom);
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0), rw,
                  ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_word_rotator.md
# hex_word_rotator

Sequential character source for the HEX display bank. It holds a word of 3-bit character codes, one per digit, and rotates it around the displays at a programmable rate or on single-step request. Each 3-bit digit output drives one `seven_seg_decoder` instance downstream. Code mapping: H=000, E=001, L=010, O=011, blank=111. The block replaces the fixed switch-to-decoder path with a scrolling message such as "HELLO".

## Interface
- `DIGITS`, default 5: number of display digits; digit DIGITS-1 is the leftmost display.
- `TICK_DIV`, default 50_000_000: clock cycles per automatic rotation. Legal range ≥1.
- `CLOCK_50`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load`  in  1: when high, captures `load_word`.
- `load_word`  in  3*DIGITS: digit i is bits [3i+2:3i].
- `run`  in  1: when high, enables the prescaler and automatic rotation.
- `dir`  in  1: 0 = scroll left (toward higher digit index); 1 = scroll right.
- `step`  in  1: single-cycle request for one rotation.
- `char_out`  out  3*DIGITS: registered word; digit i goes to decoder i.
- `pos`  out  clog2(DIGITS), min 1: rotation offset from the last load, mod DIGITS.
- `tick`  out  1: registered one-cycle strobe for a prescaler-driven rotation.

## Operation
- Reset sets `char_out` to all digits 111 (blank), `pos` to 0, `tick` to 0 and the prescaler count to 0.
- Prescaler:
  - When `run`=1, the count advances 0..TICK_DIV-1 and wraps to 0.
  - When `run`=0, the count holds its value; it is not cleared.
- An automatic advance occurs at an edge where `run`=1 and count==TICK_DIV-1.
- Advance request = automatic advance OR `step`. If both occur in the same cycle, the word rotates exactly once.
- Left rotate (`dir`=0):
  - digit i ← digit i-1, and digit 0 ← digit DIGITS-1.
  - `pos` ← (pos+1) mod DIGITS.
- Right rotate (`dir`=1):
  - digit i ← digit i+1, and digit DIGITS-1 ← digit 0.
  - `pos` ← (pos-1) mod DIGITS, so 0 wraps to DIGITS-1.
- `dir` is sampled only at the advance edge. Changing it between advances has no other effect.
- Priority: `reset` > `load` > advance.
  - `load` sets `char_out` to `load_word`, `pos` to 0 and the prescaler count to 0.
  - `load` suppresses any coincident advance and `tick`.
- The block never alters character codes. Codes 100–110 pass through unchanged.

## Timing
- All outputs are registered.
- `char_out` and `pos` reflect an advance or load in the cycle after the causing edge (latency 1).
- `tick`:
  - Goes high at the same edge an automatic rotation is applied and stays high for exactly one cycle, coincident with the new `char_out`.
  - Is not asserted for `step`-only rotations.
- With `run` held high, `tick` period is TICK_DIV cycles. The first tick after load or reset occurs TICK_DIV cycles after `run` first samples high.
- TICK_DIV=1 gives a rotation and `tick` on every cycle while `run`=1.
- Holding `step` high for N cycles gives N rotations. Pulse generation and debouncing are upstream.
- Reset asserted mid-count takes effect at the next edge, regardless of other inputs.

## Structure
- Shared package `hex_chars_pkg`:
  - Constants: `CHAR_W`=3, `CH_H`, `CH_E`, `CH_L`, `CH_O`, `CH_BLANK`.
  - Helper constant `HELLO_WORD` for 5 digits.
- One sub-module, `tick_prescaler`, with parameter TICK_DIV and ports `CLOCK_50`, `reset`, `en`=run, `clr`=load and `tick`.
- The word register, rotate mux and `pos` counter stay in the top.

## Test plan
DIGITS=5, TICK_DIV=4 for all scenarios.
- Reset: assert `reset` 2 cycles with random inputs → `char_out`=15'h7FFF, `pos`=0, `tick`=0.
- Load: `load`=1 with digits4..0 = H,E,L,L,O → next cycle `char_out` = 000_001_010_010_011, `pos`=0.
- Left scroll: `run`=1, `dir`=0 → `tick` every 4th cycle.
  - After tick 1, digits4..0 = E,L,L,O,H and `pos`=1.
  - After tick 5, the word is back to HELLO with `pos`=0.
- Right scroll: `dir`=1 from HELLO → O,H,E,L,L and `pos`=4. The next tick gives L,O,H,E,L and `pos`=3.
- Step:
  - With `run`=0, a 1-cycle `step` → one left rotation, `tick` stays 0, prescaler count unchanged.
  - With `run`=1, `step` coincident with tick → single rotation only.
- Priority:
  - `load` coincident with tick → loaded word, `pos`=0, no `tick`, and the next tick arrives 4 cycles later.
  - `reset` asserted mid-count → blank word and `pos`=0 next cycle.
